// File: rtl/mem_bypass_stage.sv
// Two-deep memory pipeline (MS1, MS2) exposing forwarding bundles for both stages.
// MS2 aligns load data and buffers the SRAM word so a stalled load keeps its value.
module mem_bypass_stage #(
    parameter int DEST_WD   = 5,
    parameter int RESULT_WD = 32,
    parameter int CTRL_WD   = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic [5:0]           stall,
    input  logic                 es_valid,
    input  logic                 es_reg_we,
    input  logic [DEST_WD-1:0]   es_dest,
    input  logic [RESULT_WD-1:0] es_result,
    input  logic [2:0]           es_load_op,
    input  logic [31:0]          data_sram_rdata,
    output logic                 ms1_reg_we,
    output logic [DEST_WD-1:0]   ms1_dest,
    output logic [RESULT_WD-1:0] ms1_result,
    output logic [CTRL_WD-1:0]   ms1_ctrl,
    output logic                 ms2_reg_we,
    output logic [DEST_WD-1:0]   ms2_dest,
    output logic [RESULT_WD-1:0] ms2_result,
    output logic [CTRL_WD-1:0]   ms2_ctrl
);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;

    // Misaligned halfword/word accesses simply drop the address bits they cannot use.
    function automatic logic [31:0] align_load(input logic [2:0]  op,
                                               input logic [1:0]  addr,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (op)
            LD_B:    r = {{24{b[7]}}, b};
            LD_BU:   r = {24'd0, b};
            LD_H:    r = {{16{h[15]}}, h};
            LD_HU:   r = {16'd0, h};
            LD_W:    r = word;
            default: r = word;
        endcase
        return r;
    endfunction

    logic                 ms1_valid_q,   ms1_valid_d;
    logic                 ms1_reg_we_q,  ms1_reg_we_d;
    logic [DEST_WD-1:0]   ms1_dest_q,    ms1_dest_d;
    logic [RESULT_WD-1:0] ms1_result_q,  ms1_result_d;
    logic [2:0]           ms1_load_op_q, ms1_load_op_d;

    logic                 ms2_valid_q,   ms2_valid_d;
    logic                 ms2_reg_we_q,  ms2_reg_we_d;
    logic [DEST_WD-1:0]   ms2_dest_q,    ms2_dest_d;
    logic [RESULT_WD-1:0] ms2_result_q,  ms2_result_d;
    logic [2:0]           ms2_load_op_q, ms2_load_op_d;

    logic                 buf_valid_q,   buf_valid_d;
    logic [31:0]          buf_data_q,    buf_data_d;

    logic                 ms2_hold;
    logic                 ms1_is_load;
    logic                 ms2_is_load;
    logic [31:0]          ld_word;
    logic [31:0]          ld_aligned;
    logic                 unused_stall;

    assign unused_stall = ^stall[2:0];
    assign ms2_hold     = !flush && stall[4] && stall[5];

    always_comb begin
        // EX -> MS1 boundary
        ms1_valid_d   = ms1_valid_q;
        ms1_reg_we_d  = ms1_reg_we_q;
        ms1_dest_d    = ms1_dest_q;
        ms1_result_d  = ms1_result_q;
        ms1_load_op_d = ms1_load_op_q;
        if (flush) begin
            ms1_valid_d = 1'b0;
        end else if (stall[3]) begin
            if (!stall[4]) begin
                ms1_valid_d = 1'b0;
            end
        end else begin
            ms1_valid_d   = es_valid;
            ms1_reg_we_d  = es_reg_we;
            ms1_dest_d    = es_dest;
            ms1_result_d  = es_result;
            ms1_load_op_d = (es_load_op > LD_W) ? LD_NONE : es_load_op;
        end

        // MS1 -> MS2 boundary
        ms2_valid_d   = ms2_valid_q;
        ms2_reg_we_d  = ms2_reg_we_q;
        ms2_dest_d    = ms2_dest_q;
        ms2_result_d  = ms2_result_q;
        ms2_load_op_d = ms2_load_op_q;
        if (flush) begin
            ms2_valid_d = 1'b0;
        end else if (stall[4]) begin
            if (!stall[5]) begin
                ms2_valid_d = 1'b0;
            end
        end else begin
            ms2_valid_d   = ms1_valid_q;
            ms2_reg_we_d  = ms1_reg_we_q;
            ms2_dest_d    = ms1_dest_q;
            ms2_result_d  = ms1_result_q;
            ms2_load_op_d = ms1_load_op_q;
        end

        // The SRAM word is only presented once, so keep it while the load sits in MS2.
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (!ms2_hold) begin
            buf_valid_d = 1'b0;
        end else if (ms2_valid_q && ms2_is_load && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms1_valid_q   <= 1'b0;
            ms1_reg_we_q  <= 1'b0;
            ms1_dest_q    <= '0;
            ms1_result_q  <= '0;
            ms1_load_op_q <= LD_NONE;
            ms2_valid_q   <= 1'b0;
            ms2_reg_we_q  <= 1'b0;
            ms2_dest_q    <= '0;
            ms2_result_q  <= '0;
            ms2_load_op_q <= LD_NONE;
            buf_valid_q   <= 1'b0;
            buf_data_q    <= '0;
        end else begin
            ms1_valid_q   <= ms1_valid_d;
            ms1_reg_we_q  <= ms1_reg_we_d;
            ms1_dest_q    <= ms1_dest_d;
            ms1_result_q  <= ms1_result_d;
            ms1_load_op_q <= ms1_load_op_d;
            ms2_valid_q   <= ms2_valid_d;
            ms2_reg_we_q  <= ms2_reg_we_d;
            ms2_dest_q    <= ms2_dest_d;
            ms2_result_q  <= ms2_result_d;
            ms2_load_op_q <= ms2_load_op_d;
            buf_valid_q   <= buf_valid_d;
            buf_data_q    <= buf_data_d;
        end
    end

    assign ms1_is_load = ms1_valid_q && (ms1_load_op_q != LD_NONE);
    assign ms2_is_load = (ms2_load_op_q != LD_NONE);

    assign ms1_reg_we  = ms1_valid_q && ms1_reg_we_q;
    assign ms1_dest    = ms1_dest_q;
    assign ms1_result  = ms1_result_q;
    assign ms1_ctrl    = CTRL_WD'(ms1_is_load);

    // In the capture cycle the raw SRAM word feeds the aligner directly.
    assign ld_word     = buf_valid_q ? buf_data_q : data_sram_rdata;
    assign ld_aligned  = align_load(ms2_load_op_q, ms2_result_q[1:0], ld_word);

    assign ms2_reg_we  = ms2_valid_q && ms2_reg_we_q;
    assign ms2_dest    = ms2_dest_q;
    assign ms2_result  = ms2_is_load ? RESULT_WD'(ld_aligned) : ms2_result_q;
    assign ms2_ctrl    = '0;

endmodule

// File: tb/tb_mem_bypass_stage.sv
// Bench for mem_bypass_stage: directed vector table, mid-cycle reset sequence,
// then randomized traffic against a behavioural model of the two memory stages.
module tb_mem_bypass_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [5:0]  stall;
    logic        es_valid;
    logic        es_reg_we;
    logic [4:0]  es_dest;
    logic [31:0] es_result;
    logic [2:0]  es_load_op;
    logic [31:0] data_sram_rdata;
    logic        ms1_reg_we;
    logic [4:0]  ms1_dest;
    logic [31:0] ms1_result;
    logic [1:0]  ms1_ctrl;
    logic        ms2_reg_we;
    logic [4:0]  ms2_dest;
    logic [31:0] ms2_result;
    logic [1:0]  ms2_ctrl;

    int checks = 0;
    int errors = 0;

    mem_bypass_stage #(.DEST_WD(5), .RESULT_WD(32), .CTRL_WD(2)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .es_valid(es_valid), .es_reg_we(es_reg_we), .es_dest(es_dest),
        .es_result(es_result), .es_load_op(es_load_op),
        .data_sram_rdata(data_sram_rdata),
        .ms1_reg_we(ms1_reg_we), .ms1_dest(ms1_dest), .ms1_result(ms1_result), .ms1_ctrl(ms1_ctrl),
        .ms2_reg_we(ms2_reg_we), .ms2_dest(ms2_dest), .ms2_result(ms2_result), .ms2_ctrl(ms2_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [5:0]  st;
        logic        ev;
        logic [4:0]  ed;
        logic [31:0] er;
        logic [2:0]  eo;
        logic [31:0] rd;
        logic        x1we;
        logic [1:0]  x1c;
        logic        c1;
        logic [4:0]  x1d;
        logic [31:0] x1r;
        logic        x2we;
        logic        c2;
        logic [4:0]  x2d;
        logic [31:0] x2r;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        bit        v;
        bit        we;
        bit [4:0]  dest;
        bit [31:0] res;
        int        op;
    } slot_t;

    slot_t     m1, m2;
    bit        have_word;
    bit [31:0] held_word;

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SH = 6'b110000;
    localparam logic [5:0] SB = 6'b001000;
    localparam logic [5:0] SF = 6'b111000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic x1we, input logic [1:0] x1c,
                                 input logic c1, input logic [4:0] x1d, input logic [31:0] x1r,
                                 input logic x2we, input logic c2, input logic [4:0] x2d,
                                 input logic [31:0] x2r);
        chk($sformatf("%s ms1_reg_we", tag), 32'(ms1_reg_we), 32'(x1we));
        chk($sformatf("%s ms1_ctrl", tag), 32'(ms1_ctrl), 32'(x1c));
        chk($sformatf("%s ms2_reg_we", tag), 32'(ms2_reg_we), 32'(x2we));
        chk($sformatf("%s ms2_ctrl", tag), 32'(ms2_ctrl), 32'd0);
        if (c1) begin
            chk($sformatf("%s ms1_dest", tag), 32'(ms1_dest), 32'(x1d));
            chk($sformatf("%s ms1_result", tag), ms1_result, x1r);
        end
        if (c2) begin
            chk($sformatf("%s ms2_dest", tag), 32'(ms2_dest), 32'(x2d));
            chk($sformatf("%s ms2_result", tag), ms2_result, x2r);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s ms1_reg_we", tag), 32'(ms1_reg_we), 32'd0);
        chk($sformatf("%s ms1_dest", tag), 32'(ms1_dest), 32'd0);
        chk($sformatf("%s ms1_result", tag), ms1_result, 32'd0);
        chk($sformatf("%s ms1_ctrl", tag), 32'(ms1_ctrl), 32'd0);
        chk($sformatf("%s ms2_reg_we", tag), 32'(ms2_reg_we), 32'd0);
        chk($sformatf("%s ms2_dest", tag), 32'(ms2_dest), 32'd0);
        chk($sformatf("%s ms2_result", tag), ms2_result, 32'd0);
        chk($sformatf("%s ms2_ctrl", tag), 32'(ms2_ctrl), 32'd0);
    endtask

    task automatic drive(input logic fl, input logic [5:0] st, input logic ev, input logic we,
                         input logic [4:0] ed, input logic [31:0] er, input logic [2:0] eo,
                         input logic [31:0] rd);
        flush = fl; stall = st; es_valid = ev; es_reg_we = we;
        es_dest = ed; es_result = er; es_load_op = eo; data_sram_rdata = rd;
    endtask

    task automatic row(input logic fl, input logic [5:0] st, input logic ev, input logic [4:0] ed,
                       input logic [31:0] er, input logic [2:0] eo, input logic [31:0] rd,
                       input logic x1we, input logic [1:0] x1c, input logic c1, input logic [4:0] x1d,
                       input logic [31:0] x1r, input logic x2we, input logic c2,
                       input logic [4:0] x2d, input logic [31:0] x2r);
        vec_t v;
        v.fl = fl; v.st = st; v.ev = ev; v.ed = ed; v.er = er; v.eo = eo; v.rd = rd;
        v.x1we = x1we; v.x1c = x1c; v.c1 = c1; v.x1d = x1d; v.x1r = x1r;
        v.x2we = x2we; v.c2 = c2; v.x2d = x2d; v.x2r = x2r;
        tbl.push_back(v);
    endtask

    function automatic bit is_load(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    // Extract the loaded value with shifts and masks, sign-extending by subtraction.
    function automatic logic [31:0] load_val(input int op, input logic [31:0] addr, input logic [31:0] w);
        longint x;
        int a;
        a = int'(addr[1:0]);
        case (op)
            1, 2: begin
                x = longint'((w >> (8 * a)) & 32'hFF);
                if (op == 1 && x >= 128) x = x - 256;
            end
            3, 4: begin
                x = longint'((w >> (16 * (a / 2))) & 32'hFFFF);
                if (op == 3 && x >= 32768) x = x - 65536;
            end
            default: x = longint'(w);
        endcase
        return x[31:0];
    endfunction

    initial begin
        drive(0, S0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // fl st ev ed er eo rd | x1we x1c c1 x1d x1r | x2we c2 x2d x2r
        row(0, S0, 1, 5,  32'h1234, 0, 0,            0, 0, 1, 0,  0,        0, 1, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 0, 1, 5,  32'h1234, 0, 1, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            0, 0, 0, 0,  0,        1, 1, 5,  32'h1234);
        row(0, S0, 1, 7,  32'h1003, 1, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 1, 1, 7,  32'h1003, 0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 32'h80FF0000, 0, 0, 0, 0,  0,        1, 1, 7,  32'hFFFFFF80);
        row(0, S0, 1, 8,  32'h1003, 2, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 1, 1, 8,  32'h1003, 0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 32'h80FF0000, 0, 0, 0, 0,  0,        1, 1, 8,  32'h00000080);
        row(0, S0, 1, 9,  32'h2002, 3, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 1, 1, 9,  32'h2002, 0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 32'h80FF0000, 0, 0, 0, 0,  0,        1, 1, 9,  32'hFFFF80FF);
        row(0, S0, 1, 10, 32'h3000, 5, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 1, 1, 10, 32'h3000, 0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 32'h80FF0000, 0, 0, 0, 0,  0,        1, 1, 10, 32'h80FF0000);
        row(0, S0, 1, 11, 32'h4000, 5, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            1, 1, 1, 11, 32'h4000, 0, 0, 0,  0);
        row(0, SH, 0, 0,  0,        0, 32'hDEADBEEF, 0, 0, 0, 0,  0,        1, 1, 11, 32'hDEADBEEF);
        row(0, SH, 0, 0,  0,        0, 32'h12345678, 0, 0, 0, 0,  0,        1, 1, 11, 32'hDEADBEEF);
        row(0, SH, 0, 0,  0,        0, 32'hAAAAAAAA, 0, 0, 0, 0,  0,        1, 1, 11, 32'hDEADBEEF);
        row(0, S0, 0, 0,  0,        0, 32'h55555555, 0, 0, 0, 0,  0,        1, 1, 11, 32'hDEADBEEF);
        row(0, S0, 0, 0,  0,        0, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 1, 12, 32'h1111, 0, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, SB, 1, 13, 32'h2222, 0, 0,            1, 0, 1, 12, 32'h1111, 0, 0, 0,  0);
        row(0, S0, 1, 13, 32'h2222, 0, 0,            0, 0, 0, 0,  0,        1, 1, 12, 32'h1111);
        row(0, S0, 0, 0,  0,        0, 0,            1, 0, 1, 13, 32'h2222, 0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            0, 0, 0, 0,  0,        1, 1, 13, 32'h2222);
        row(0, S0, 1, 14, 32'h5000, 5, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 1, 15, 32'h5001, 1, 0,            1, 1, 1, 14, 32'h5000, 0, 0, 0,  0);
        row(1, S0, 0, 0,  0,        0, 32'h01020304, 1, 1, 1, 15, 32'h5001, 1, 1, 14, 32'h01020304);
        row(0, S0, 0, 0,  0,        0, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(0, S0, 1, 16, 32'h16,   0, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);
        row(1, SF, 0, 0,  0,        0, 0,            1, 0, 1, 16, 32'h16,   0, 0, 0,  0);
        row(0, S0, 0, 0,  0,        0, 0,            0, 0, 0, 0,  0,        0, 0, 0,  0);

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk);
            drive(v.fl, v.st, v.ev, v.ev, v.ed, v.er, v.eo, v.rd);
            #1 check_outputs($sformatf("vec%0d", i), v.x1we, v.x1c, v.c1, v.x1d, v.x1r,
                             v.x2we, v.c2, v.x2d, v.x2r);
        end

        // Buffered load in MS2, reset pulled low between clock edges.
        @(negedge clk); drive(0, S0, 1, 1, 20, 32'h6000, 5, 0);
        @(negedge clk); drive(0, S0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, SH, 1, 1, 21, 32'h21, 0, 32'hCAFEF00D);
        #1 chk("rstseq capture ms2_result", ms2_result, 32'hCAFEF00D);
        @(negedge clk); drive(0, SH, 0, 0, 0, 0, 0, 32'h11111111);
        #1 chk("rstseq held ms2_result", ms2_result, 32'hCAFEF00D);
        chk("rstseq ms1_reg_we", 32'(ms1_reg_we), 32'd1);
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("in_reset");
        resetn = 1'b1;
        drive(0, S0, 1, 1, 22, 32'h7002, 4, 32'h12345678);
        @(negedge clk); drive(0, S0, 0, 0, 0, 0, 0, 0);
        #1 chk("resume ms1_reg_we", 32'(ms1_reg_we), 32'd1);
        chk("resume ms1_ctrl", 32'(ms1_ctrl), 32'd1);
        @(negedge clk); drive(0, S0, 0, 0, 0, 0, 0, 32'h0BADCAFE);
        #1 chk("resume ms2_reg_we", 32'(ms2_reg_we), 32'd1);
        chk("resume ms2_dest", 32'(ms2_dest), 32'd22);
        chk("resume ms2_result", ms2_result, 32'h00000BAD);

        @(negedge clk); drive(0, S0, 0, 0, 0, 0, 0, 0); resetn = 1'b0;
        @(negedge clk); resetn = 1'b1;
        m1 = '{default: 0};
        m2 = '{default: 0};
        have_word = 1'b0;
        held_word = '0;

        for (int n = 0; n < 400; n++) begin
            logic        fl;
            logic [5:0]  st;
            logic        e1we, e2we;
            logic [1:0]  e1c;
            logic [31:0] e2r;
            bit          hold2;
            fl = ($urandom_range(0, 15) == 0);
            st = 6'($urandom_range(0, 7));
            st[3] = ($urandom_range(0, 3) == 0);
            st[4] = ($urandom_range(0, 3) == 0);
            st[5] = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            drive(fl, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)), $urandom);

            e1we = m1.v && m1.we;
            e1c  = (m1.v && is_load(m1.op)) ? 2'd1 : 2'd0;
            e2we = m2.v && m2.we;
            e2r  = is_load(m2.op) ? load_val(m2.op, m2.res, have_word ? held_word : data_sram_rdata)
                                  : m2.res;
            #1 check_outputs($sformatf("rand%0d", n), e1we, e1c, m1.v, m1.dest, m1.res,
                             e2we, m2.v, m2.dest, e2r);

            hold2 = !fl && st[4] && st[5];
            if (!hold2) have_word = 1'b0;
            else if (m2.v && is_load(m2.op) && !have_word) begin
                have_word = 1'b1;
                held_word = data_sram_rdata;
            end
            if (fl) m2.v = 1'b0;
            else if (st[4] && !st[5]) m2.v = 1'b0;
            else if (!st[4]) m2 = m1;
            if (fl) m1.v = 1'b0;
            else if (st[3] && !st[4]) m1.v = 1'b0;
            else if (!st[3]) begin
                m1.v    = es_valid;
                m1.we   = es_reg_we;
                m1.dest = es_dest;
                m1.res  = es_result;
                m1.op   = int'(es_load_op);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
